// File: rtl/mlp_sample_sequencer.sv
// Streams features into the printed-MLP input bus, lets the classifier settle,
// then returns the captured class index with a running sample number.
module mlp_sample_sequencer #(
   parameter int NUM_A         = 21,
   parameter int WIDTH_A       = 4,
   parameter int OUTWIDTH      = 2,
   parameter int SETTLE_CYCLES = 4,
   parameter int IDX_W         = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [WIDTH_A-1:0]       s_data,
   input  logic                     s_last,
   output logic [NUM_A*WIDTH_A-1:0] inp,
   input  logic [OUTWIDTH-1:0]      out_cls,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [OUTWIDTH-1:0]      m_class,
   output logic [IDX_W-1:0]         m_index,
   output logic                     err_len
);

   localparam int FIDX_W = (NUM_A > 1) ? $clog2(NUM_A) : 1;
   localparam logic [FIDX_W-1:0] LAST_IDX  = FIDX_W'(NUM_A - 1);
   localparam logic [7:0]        SCNT_INIT = 8'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {LOAD, SETTLE, OUT} state_t;

   state_t            state;
   state_t            state_next;
   logic [FIDX_W-1:0] fidx;
   logic [7:0]        scnt;
   logic              beat;
   logic              final_beat;

   // Gating with rst keeps a beat presented during reset from being taken.
   assign s_ready    = (state == LOAD) && !rst;
   assign beat       = s_valid && s_ready;
   assign final_beat = beat && (fidx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOAD;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         LOAD:    if (final_beat)    state_next = SETTLE;
         SETTLE:  if (scnt == 8'd0)  state_next = OUT;
         OUT:     if (m_ready)       state_next = LOAD;
         default:                    state_next = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fidx    <= '0;
         scnt    <= '0;
         inp     <= '0;
         m_valid <= 1'b0;
         m_class <= '0;
         m_index <= '0;
         err_len <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (final_beat) begin
                  inp[int'(fidx)*WIDTH_A +: WIDTH_A] <= s_data;
                  fidx <= '0;
                  scnt <= SCNT_INIT;
                  if (!s_last) err_len <= 1'b1;
               end else if (beat && s_last) begin
                  // A short sample is discarded entirely rather than classified.
                  inp     <= '0;
                  fidx    <= '0;
                  err_len <= 1'b1;
               end else if (beat) begin
                  inp[int'(fidx)*WIDTH_A +: WIDTH_A] <= s_data;
                  fidx <= fidx + FIDX_W'(1);
               end
            end
            SETTLE: begin
               if (scnt == 8'd0) begin
                  m_class <= out_cls;
                  m_valid <= 1'b1;
               end else begin
                  scnt <= scnt - 8'd1;
               end
            end
            OUT: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  m_index <= m_index + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mlp_sample_sequencer.sv
// Scoreboard bench for mlp_sample_sequencer: a feature-array model predicts each
// result, and a negedge monitor compares whenever a new result appears.
module tb_mlp_sample_sequencer;

   localparam int NUM_A         = 21;
   localparam int WIDTH_A       = 4;
   localparam int OUTWIDTH      = 2;
   localparam int SETTLE_CYCLES = 4;
   localparam int IDX_W         = 2;
   localparam int INP_W         = NUM_A * WIDTH_A;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 s_valid;
   logic                 s_ready;
   logic [WIDTH_A-1:0]   s_data;
   logic                 s_last;
   logic [INP_W-1:0]     inp;
   logic [OUTWIDTH-1:0]  out_cls;
   logic                 m_valid;
   logic                 m_ready;
   logic [OUTWIDTH-1:0]  m_class;
   logic [IDX_W-1:0]     m_index;
   logic                 err_len;

   logic [OUTWIDTH-1:0]  cls_flip;
   logic                 rand_ready;
   logic                 ready_level;
   int                   stub_sum;

   typedef struct {
      logic [OUTWIDTH-1:0] cls;
      logic [IDX_W-1:0]    idx;
      logic [INP_W-1:0]    img;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   model_feat[NUM_A];
   int   model_pos;
   int   model_count;
   int   check_count = 0;
   int   pass_count  = 0;

   logic                prev_valid = 1'b0;
   logic [OUTWIDTH-1:0] prev_cls;
   logic [IDX_W-1:0]    prev_idx;
   logic [INP_W-1:0]    prev_inp;

   mlp_sample_sequencer #(
      .NUM_A(NUM_A), .WIDTH_A(WIDTH_A), .OUTWIDTH(OUTWIDTH),
      .SETTLE_CYCLES(SETTLE_CYCLES), .IDX_W(IDX_W)
   ) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .inp(inp), .out_cls(out_cls),
      .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_index(m_index),
      .err_len(err_len)
   );

   always #5 clk = ~clk;

   // Classifier stand-in: feature sum modulo 2^OUTWIDTH, optionally perturbed.
   always_comb begin
      stub_sum = 0;
      for (int k = 0; k < NUM_A; k++) stub_sum += int'(inp[k*WIDTH_A +: WIDTH_A]);
      out_cls = OUTWIDTH'(stub_sum) ^ cls_flip;
   end

   always @(negedge clk) begin
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
   end

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      check_count++;
      if (actual === expected) pass_count++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   function automatic logic [INP_W-1:0] modelImage();
      logic [INP_W-1:0] img;
      img = '0;
      for (int k = 0; k < NUM_A; k++) img[k*WIDTH_A +: WIDTH_A] = WIDTH_A'(model_feat[k]);
      return img;
   endfunction

   function automatic logic [OUTWIDTH-1:0] modelClass();
      int sum;
      sum = 0;
      for (int k = 0; k < NUM_A; k++) sum += model_feat[k];
      return OUTWIDTH'(sum) ^ cls_flip;
   endfunction

   task automatic modelReset();
      sb.delete();
      for (int k = 0; k < NUM_A; k++) model_feat[k] = 0;
      model_pos   = 0;
      model_count = 0;
   endtask

   // Apply a one-cycle reset and confirm every output returns to its idle value.
   task automatic applyReset();
      @(negedge clk);
      rst     = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      @(posedge clk);
      #1;
      modelReset();
      checkOutput("s_ready during reset", s_ready, 0);
      checkOutput("reset outputs", {m_valid, m_class, m_index, err_len, inp}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("s_ready after reset", s_ready, 1);
   endtask

   task automatic applyStimulus(input logic [WIDTH_A-1:0] data, input logic last, input int gap);
      int waited;
      waited = 0;
      for (int g = 0; g < gap; g++) @(negedge clk);
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = data;
      s_last  = last;
      while (!s_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!s_ready) begin
         checkOutput("s_ready wait", s_ready, 1);
         s_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      model_feat[model_pos] = int'(data);
      if (model_pos == NUM_A - 1) begin
         exp_t e;
         model_pos = 0;
         e.cls = modelClass();
         e.idx = IDX_W'(model_count);
         e.img = modelImage();
         sb.push_back(e);
         model_count++;
      end else if (last) begin
         for (int k = 0; k < NUM_A; k++) model_feat[k] = 0;
         model_pos = 0;
      end else begin
         model_pos++;
      end
   endtask

   task automatic sendSample(input int lastPos, input bit markLast, input bit patterned,
                             input int maxGap);
      for (int k = 0; k <= lastPos; k++) begin
         applyStimulus(patterned ? WIDTH_A'(k % 16) : WIDTH_A'($urandom),
                       markLast && (k == lastPos),
                       (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
      end
   endtask

   task automatic waitValid(output int cycles);
      cycles = 0;
      while (cycles < 100) begin
         @(posedge clk);
         #1;
         cycles++;
         if (m_valid) return;
      end
      checkOutput("m_valid wait", m_valid, 1);
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!m_valid && sb.size() == 0) return;
      end
      checkOutput("drain timeout", sb.size(), 0);
   endtask

   // Monitor: pop on each new result, and demand a frozen result while it waits.
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (m_valid && !prev_valid) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected result", m_valid, 0);
            end else begin
               mon_e = sb.pop_front();
               checkOutput("m_class", m_class, mon_e.cls);
               checkOutput("m_index", m_index, mon_e.idx);
               checkOutput("inp at capture", inp, mon_e.img);
            end
         end else if (m_valid && prev_valid) begin
            checkOutput("held result", {s_ready, m_class, m_index, inp},
                        {1'b0, prev_cls, prev_idx, prev_inp});
         end
         prev_valid = m_valid;
         prev_cls   = m_class;
         prev_idx   = m_index;
         prev_inp   = inp;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      logic any_valid;
      rst         = 1'b1;
      s_valid     = 1'b0;
      s_data      = '0;
      s_last      = 1'b0;
      cls_flip    = '0;
      rand_ready  = 1'b0;
      ready_level = 1'b1;
      modelReset();
      applyReset();

      // Patterned sample: value k mod 16 in slot k.
      sendSample(NUM_A - 1, 1'b1, 1'b1, 0);
      checkOutput("inp slot 20", inp[20*WIDTH_A +: WIDTH_A], 4);
      checkOutput("inp slot 15", inp[15*WIDTH_A +: WIDTH_A], 15);
      waitValid(lat);
      checkOutput("result latency", lat, SETTLE_CYCLES);
      checkOutput("err_len clean sample", err_len, 0);
      waitIdle();

      // Backpressure while the stub output wanders.
      applyReset();
      ready_level = 1'b0;
      sendSample(NUM_A - 1, 1'b1, 1'b0, 0);
      waitValid(lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         cls_flip = OUTWIDTH'($urandom);
         checkOutput("m_valid held", m_valid, 1);
      end
      @(negedge clk);
      ready_level = 1'b1;
      cls_flip    = '0;
      waitIdle();
      sendSample(NUM_A - 1, 1'b1, 1'b0, 2);
      waitIdle();

      // Early s_last aborts the sample.
      applyReset();
      sendSample(5, 1'b1, 1'b0, 0);
      checkOutput("inp after abort", inp, 0);
      checkOutput("err_len after abort", err_len, 1);
      any_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         any_valid |= m_valid;
      end
      checkOutput("no result after abort", any_valid, 0);
      sendSample(NUM_A - 1, 1'b1, 1'b0, 0);
      waitIdle();
      checkOutput("err_len sticky", err_len, 1);

      // Missing s_last still yields a result but flags framing.
      applyReset();
      sendSample(NUM_A - 1, 1'b0, 1'b0, 0);
      checkOutput("err_len missing last", err_len, 1);
      waitIdle();

      // Reset in the second SETTLE cycle drops the pending result.
      applyReset();
      sendSample(NUM_A - 1, 1'b1, 1'b0, 0);
      @(posedge clk);
      applyReset();
      any_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         any_valid |= m_valid;
      end
      checkOutput("no result after reset", any_valid, 0);
      sendSample(NUM_A - 1, 1'b1, 1'b0, 0);
      waitIdle();

      // Index wrap with random gaps and random m_ready.
      applyReset();
      rand_ready = 1'b1;
      for (int s = 0; s < 5; s++) sendSample(NUM_A - 1, 1'b1, 1'b0, 3);
      waitIdle();
      rand_ready = 1'b0;
      checkOutput("wrap sample count", model_count, 5);

      repeat (3) @(negedge clk);
      checkOutput("scoreboard empty", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/mlp_sample_sequencer.md
# mlp_sample_sequencer

Clocked front/back end for the combinational printed-MLP classifier (`top`, flat `inp` bus in, `out` class index out). It deserializes a stream of WIDTH_A-bit features, one per handshake, into the packed `inp` bus, then holds it stable for a programmable settle time. It then captures the class index and returns it over a valid/ready result port tagged with a running sample index. It replaces file-driven stimulus when the classifier is exercised from an on-chip or FPGA host stream.

## Interface
- NUM_A, 21, features per sample
- WIDTH_A, 4, bits per feature
- OUTWIDTH, 2, width of classifier class index
- SETTLE_CYCLES, 4, cycles `inp` is held stable before capture; legal range is 1 to 255
- IDX_W, 16, width of sample index counter
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- s_valid  in  1  feature valid
- s_ready  out  1  feature accept
- s_data  in  WIDTH_A  feature value (unsigned)
- s_last  in  1  marks final feature of a sample
- inp  out  NUM_A*WIDTH_A  packed features to classifier; feature k at bits [(k+1)*WIDTH_A-1 : k*WIDTH_A]
- out_cls  in  OUTWIDTH  classifier result (combinational from `inp`)
- m_valid  out  1  result valid
- m_ready  in  1  result accept
- m_class  out  OUTWIDTH  captured class index
- m_index  out  IDX_W  sample number of current result, counting from 0
- err_len  out  1  sticky framing error

## Operation
- The FSM has three states: LOAD, SETTLE, OUT.
- LOAD:
  - `s_ready`=1.
  - Each s_valid&s_ready beat writes s_data into feature slot `fidx`, then increments `fidx`.
  - Slots not yet written in this sample keep their previous values.
- Beat with fidx==NUM_A-1 goes to SETTLE, loads `scnt`=SETTLE_CYCLES-1, clears fidx.
  - If s_last=0 on that beat: set err_len and proceed normally.
- Early-last beat (s_last=1 with fidx<NUM_A-1):
  - The beat is written to its slot.
  - The sample is aborted: all of `inp` is cleared to 0, fidx=0, err_len=1.
  - State stays LOAD, no result is produced, and m_index is unchanged.
- SETTLE:
  - s_ready=0.
  - Decrement scnt each cycle.
  - In the cycle scnt==0, capture out_cls into m_class, set m_valid=1, and go to OUT.
- OUT:
  - s_ready=0.
  - Hold m_valid, m_class and m_index stable until m_valid&m_ready.
  - On handshake: m_valid=0, m_index increments (wrapping 2^IDX_W-1 → 0), go to LOAD.
- `inp` is driven only from the feature register. It never changes during SETTLE or OUT.
- err_len is cleared only by rst.

## Timing
- Reset values:
  - state=LOAD, fidx=0, scnt=0.
  - inp=0, m_valid=0, m_class=0, m_index=0, err_len=0.
  - s_ready is 0 in any cycle with rst=1, and 1 in the first cycle after reset is released.
- The final feature is accepted at edge T.
  - `inp` is complete from T.
  - The capture edge is T+SETTLE_CYCLES.
  - m_valid is visible after edge T+SETTLE_CYCLES.
- Minimum sample period with m_ready tied high is NUM_A + SETTLE_CYCLES + 1 cycles.
- s_ready is registered-state-derived, with no combinational path from s_valid.
- m_valid does not depend combinationally on m_ready.
- The first feature of the next sample can be accepted the cycle after the result handshake.
- Reset mid-operation (any state) returns everything to reset values in one cycle. A pending result is dropped.
- An s_valid beat with rst=1 is not accepted.

## Test plan
- Single sample, SETTLE_CYCLES=4, m_ready=1, features k=0..20 with value k mod 16, s_last on k=20:
  - `inp` slot 20 reads 4, slot 15 reads 15.
  - m_valid rises 4 cycles after the last beat.
  - m_class equals the stubbed out_cls, m_index=0, err_len=0.
- Backpressure: hold m_ready=0 for 10 cycles after m_valid.
  - m_valid, m_class and m_index stay stable.
  - s_ready=0 throughout.
  - out_cls changes in the stub have no effect on m_class.
  - After release, m_index=1 on the next sample.
- Early s_last on feature 5:
  - inp=0, err_len=1, no m_valid.
  - The next full 21-feature sample produces a result with m_index=0.
- Missing s_last on feature 20: the result is still produced and err_len=1.
- Reset asserted in SETTLE (2nd cycle):
  - All outputs return to reset values and no result emerges.
  - A fresh sample then completes normally with m_index=0.
- Index wrap with IDX_W=2, 5 back-to-back samples with random s_valid gaps: m_index sequence is 0,1,2,3,0.
